// File: rtl/op_sequencer_pkg.sv
// Shared definitions for the op sequencer and the CU: opcode set, sequencer FSM
// states and instruction-word field helpers for the default 4+8 bit word.
package op_sequencer_pkg;

   localparam int SEQ_OP_W  = 4;
   localparam int SEQ_ARG_W = 8;

   localparam logic [SEQ_OP_W-1:0] OP_ADD        = 4'h0;
   localparam logic [SEQ_OP_W-1:0] OP_SUB        = 4'h1;
   localparam logic [SEQ_OP_W-1:0] OP_MUL        = 4'h2;
   localparam logic [SEQ_OP_W-1:0] OP_DIV        = 4'h3;
   localparam logic [SEQ_OP_W-1:0] OP_MAC        = 4'h4;
   localparam logic [SEQ_OP_W-1:0] OP_MAX        = 4'h5;
   localparam logic [SEQ_OP_W-1:0] OP_RELU       = 4'h6;
   localparam logic [SEQ_OP_W-1:0] OP_SIGD_DEF   = 4'h7;
   localparam logic [SEQ_OP_W-1:0] OP_LOOP_BEGIN = 4'h8;
   localparam logic [SEQ_OP_W-1:0] OP_LOOP_END   = 4'h9;
   localparam logic [SEQ_OP_W-1:0] OP_HALT       = 4'hE;
   localparam logic [SEQ_OP_W-1:0] OP_NOP        = 4'hF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_ISSUE,
      ST_DONE
   } seq_state_e;

   function automatic logic [SEQ_OP_W-1:0] instr_op(input logic [SEQ_OP_W+SEQ_ARG_W-1:0] w);
      return w[SEQ_OP_W+SEQ_ARG_W-1 -: SEQ_OP_W];
   endfunction

   function automatic logic [SEQ_ARG_W-1:0] instr_arg(input logic [SEQ_OP_W+SEQ_ARG_W-1:0] w);
      return w[SEQ_ARG_W-1:0];
   endfunction

   // Opcodes the CU executes; everything above is resolved inside the sequencer.
   function automatic logic is_cu_op(input logic [SEQ_OP_W-1:0] op);
      return op <= OP_SIGD_DEF;
   endfunction

endpackage

// File: rtl/seq_prog_ram.sv
// Program store for the op sequencer: one write port, one synchronous read port
// with a read enable so the output word holds between fetches.
module seq_prog_ram #(
   parameter int DEPTH  = 32,
   parameter int WIDTH  = 12,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [WIDTH-1:0]  wdata_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [WIDTH-1:0]  rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_o <= mem_q[raddr_i];
      end
   end

endmodule

// File: rtl/op_sequencer.sv
// Instruction issuer for the CU: fetches {opcode,arg} words, resolves loops/HALT/NOP
// locally and issues CU opcodes over valid/ready. Optional: SEQ_SINGLE_STEP_EN.
module op_sequencer
   import op_sequencer_pkg::*;
#(
   parameter int OP_WIDTH   = 4,
   parameter int ARG_WIDTH  = 8,
   parameter int PROG_DEPTH = 32,
   parameter int PC_W       = $clog2(PROG_DEPTH)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          prog_we,
   input  logic [PC_W-1:0]               prog_addr,
   input  logic [OP_WIDTH+ARG_WIDTH-1:0] prog_data,
   input  logic                          start,
   input  logic                          op_ready,
`ifdef SEQ_SINGLE_STEP_EN
   input  logic                          step_en,
   input  logic                          step,
`endif
   output logic                          op_valid,
   output logic [OP_WIDTH-1:0]           opcode,
   output logic [ARG_WIDTH-1:0]          op_arg,
   output logic                          busy,
   output logic                          done
);

   localparam int INSTR_W = OP_WIDTH + ARG_WIDTH;

   seq_state_e           state_q, state_d;
   logic [PC_W-1:0]      pc_q, pc_d;
   logic [PC_W-1:0]      loop_pc_q, loop_pc_d;
   logic [ARG_WIDTH-1:0] loop_cnt_q, loop_cnt_d;

   logic [INSTR_W-1:0]   instr;
   logic [OP_WIDTH-1:0]  cur_op;
   logic [ARG_WIDTH-1:0] cur_arg;
   logic                 ram_re;
   logic                 fetch_go;
   logic                 pc_last;
   seq_state_e           adv_state;
   logic [PC_W-1:0]      adv_pc;

   seq_prog_ram #(
      .DEPTH (PROG_DEPTH),
      .WIDTH (INSTR_W),
      .ADDR_W(PC_W)
   ) u_prog_ram (
      .clk    (clk),
      .we_i   (prog_we && (state_q == ST_IDLE)),
      .waddr_i(prog_addr),
      .wdata_i(prog_data),
      .re_i   (ram_re),
      .raddr_i(pc_q),
      .rdata_o(instr)
   );

   assign cur_op  = instr[INSTR_W-1 -: OP_WIDTH];
   assign cur_arg = instr[ARG_WIDTH-1:0];

`ifdef SEQ_SINGLE_STEP_EN
   assign fetch_go = !step_en || step;
`else
   assign fetch_go = 1'b1;
`endif

   // Stepping past the last word ends the program instead of wrapping to 0.
   assign pc_last   = (pc_q == PC_W'(PROG_DEPTH - 1));
   assign adv_state = pc_last ? ST_DONE : ST_FETCH;
   assign adv_pc    = pc_last ? pc_q : pc_q + PC_W'(1);

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      loop_pc_d  = loop_pc_q;
      loop_cnt_d = loop_cnt_q;
      ram_re     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start && !prog_we) begin
               state_d    = ST_FETCH;
               pc_d       = '0;
               loop_pc_d  = '0;
               loop_cnt_d = '0;
            end
         end
         ST_FETCH: begin
            if (fetch_go) begin
               ram_re  = 1'b1;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            if (is_cu_op(SEQ_OP_W'(cur_op))) begin
               state_d = ST_ISSUE;
            end else if (cur_op == OP_WIDTH'(OP_HALT)) begin
               state_d = ST_DONE;
            end else if (cur_op == OP_WIDTH'(OP_LOOP_BEGIN)) begin
               loop_pc_d  = pc_q + PC_W'(1);
               loop_cnt_d = (cur_arg == '0) ? ARG_WIDTH'(1) : cur_arg;
               state_d    = adv_state;
               pc_d       = adv_pc;
            end else if (cur_op == OP_WIDTH'(OP_LOOP_END) && loop_cnt_q > ARG_WIDTH'(1)) begin
               loop_cnt_d = loop_cnt_q - ARG_WIDTH'(1);
               pc_d       = loop_pc_q;
               state_d    = ST_FETCH;
            end else begin
               // Final LOOP_END, NOP and unused opcodes all just step on.
               if (cur_op == OP_WIDTH'(OP_LOOP_END)) begin
                  loop_cnt_d = '0;
               end
               state_d = adv_state;
               pc_d    = adv_pc;
            end
         end
         ST_ISSUE: begin
            if (op_ready) begin
               state_d = adv_state;
               pc_d    = adv_pc;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         pc_q       <= '0;
         loop_pc_q  <= '0;
         loop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         loop_pc_q  <= loop_pc_d;
         loop_cnt_q <= loop_cnt_d;
      end
   end

   // The RAM output register holds the word for the whole ISSUE phase.
   assign op_valid = (state_q == ST_ISSUE);
   assign opcode   = op_valid ? cur_op : OP_WIDTH'(OP_NOP);
   assign op_arg   = op_valid ? cur_arg : '0;
   assign busy     = (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_op_sequencer.sv
// Self-checking bench for op_sequencer: directed programs plus random programs and
// random op_ready, scored against a program-interpreting reference model.
module tb_op_sequencer;
   import op_sequencer_pkg::*;

   localparam int DEPTH = 32;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        prog_we = 1'b0;
   logic [4:0]  prog_addr = '0;
   logic [11:0] prog_data = '0;
   logic        start = 1'b0;
   logic        op_ready = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
   logic        step_en = 1'b0;
   logic        step = 1'b0;
`endif
   logic        op_valid;
   logic [3:0]  opcode;
   logic [7:0]  op_arg;
   logic        busy;
   logic        done;

   int errors = 0;
   int checks = 0;

   logic [11:0] prog_mem [DEPTH];
   logic [3:0]  exp_op [$];
   logic [7:0]  exp_arg [$];

   op_sequencer dut (
      .clk      (clk),
      .rst      (rst),
      .prog_we  (prog_we),
      .prog_addr(prog_addr),
      .prog_data(prog_data),
      .start    (start),
      .op_ready (op_ready),
`ifdef SEQ_SINGLE_STEP_EN
      .step_en  (step_en),
      .step     (step),
`endif
      .op_valid (op_valid),
      .opcode   (opcode),
      .op_arg   (op_arg),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Reference: interpret the program word by word and list the ops the CU must see.
   task automatic build_expected();
      int pc = 0;
      int nxt;
      int lc = 0;
      int lpc = 0;
      int steps = 0;
      bit fin = 0;
      logic [3:0] op;
      logic [7:0] arg;
      exp_op.delete();
      exp_arg.delete();
      while (!fin && steps < 20000) begin
         steps++;
         op  = prog_mem[pc][11:8];
         arg = prog_mem[pc][7:0];
         nxt = pc + 1;
         if (op < 4'd8) begin
            exp_op.push_back(op);
            exp_arg.push_back(arg);
         end else if (op == 4'hE) begin
            fin = 1;
         end else if (op == 4'h8) begin
            lpc = pc + 1;
            lc  = (arg == 0) ? 1 : int'(arg);
         end else if (op == 4'h9) begin
            if (lc > 1) begin
               lc--;
               nxt = lpc;
            end else begin
               lc = 0;
            end
         end
         if (!fin) begin
            if (nxt >= DEPTH) fin = 1;
            else pc = nxt;
         end
      end
   endtask

   task automatic write_prog();
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge clk);
         prog_we   = 1'b1;
         prog_addr = 5'(i);
         prog_data = prog_mem[i];
      end
      @(negedge clk);
      prog_we = 1'b0;
   endtask

   task automatic fill(input logic [11:0] w);
      for (int i = 0; i < DEPTH; i++) prog_mem[i] = w;
   endtask

   // mode 0: ready always; 1: random ready; 2: first op stalled 4 cycles
   task automatic run_prog(input string name, input int mode, input bit chk_lat);
      int cyc = 0;
      int idx = 0;
      int stall = 0;
      bit first = 1;
      bit got_done = 0;
      bit pv = 0;
      bit pr = 0;
      logic [11:0] pword = '0;
      build_expected();
      @(negedge clk);
      start    = 1'b1;
      op_ready = 1'b0;
      while (!got_done && cyc < 5000) begin
         @(negedge clk);
         start = 1'b0;
         cyc++;
         if (pv && !pr) check_val({name, " hold"}, {19'd0, op_valid, opcode, op_arg}, {19'd0, 1'b1, pword});
         if (op_valid && first) begin
            first = 0;
            if (chk_lat) check_val({name, " latency"}, cyc, 3);
         end
         if (op_valid) check_val({name, " cu_only"}, {31'd0, opcode[3]}, 0);
         if (done) begin
            got_done = 1;
            check_val({name, " busy_at_done"}, {31'd0, busy}, 0);
         end
         case (mode)
            0: op_ready = 1'b1;
            1: op_ready = ($urandom_range(0, 3) != 0);
            default: begin
               if (op_valid && idx == 0 && stall < 4) begin
                  op_ready = 1'b0;
                  stall++;
               end else begin
                  op_ready = 1'b1;
               end
            end
         endcase
         if (op_valid && op_ready) begin
            if (idx < exp_op.size())
               check_val({name, " op"}, {20'd0, opcode, op_arg}, {20'd0, exp_op[idx], exp_arg[idx]});
            else
               check_val({name, " extra_op"}, idx, exp_op.size());
            idx++;
         end
         pv    = op_valid;
         pr    = op_ready;
         pword = {opcode, op_arg};
      end
      check_val({name, " done_seen"}, {31'd0, got_done}, 1);
      check_val({name, " op_count"}, idx, exp_op.size());
      @(negedge clk);
      op_ready = 1'b0;
      check_val({name, " done_one_cycle"}, {30'd0, done, busy}, 0);
      $display("run %s: %0d ops issued, %0d expected, %0d cycles", name, idx, exp_op.size(), cyc);
   endtask

   initial begin
      int n;
      int cnt;
      logic [3:0] rop;

      repeat (2) @(negedge clk);
      check_val("reset op_valid", {31'd0, op_valid}, 0);
      check_val("reset opcode", {28'd0, opcode}, 32'hF);
      check_val("reset op_arg", {24'd0, op_arg}, 0);
      check_val("reset busy", {31'd0, busy}, 0);
      check_val("reset done", {31'd0, done}, 0);
      rst = 1'b0;

      fill(12'hE00);
      prog_mem[0] = 12'h005;
      prog_mem[1] = 12'h207;
      prog_mem[2] = 12'hE00;
      write_prog();
      run_prog("basic", 0, 1);
      run_prog("stall", 2, 1);

      // start coinciding with a write must be ignored
      @(negedge clk);
      prog_we = 1'b1; start = 1'b1; prog_addr = 5'd0; prog_data = prog_mem[0];
      @(negedge clk);
      prog_we = 1'b0; start = 1'b0;
      check_val("start_vs_we busy", {31'd0, busy}, 0);
      @(negedge clk);
      check_val("start_vs_we idle", {31'd0, busy}, 0);

      fill(12'hE00);
      prog_mem[0] = 12'h803;
      prog_mem[1] = 12'h001;
      prog_mem[2] = 12'h900;
      prog_mem[3] = 12'hE00;
      write_prog();
      run_prog("loop3", 1, 0);
      check_val("loop3 issues", exp_op.size(), 3);

      fill(12'hE00);
      prog_mem[0] = 12'hF00;
      prog_mem[1] = 12'h602;
      prog_mem[2] = 12'hE00;
      write_prog();
      run_prog("nop_relu", 1, 0);

      for (int i = 0; i < DEPTH; i++) prog_mem[i] = {4'h1, 8'(i)};
      write_prog();
      run_prog("nohalt", 1, 1);
      check_val("nohalt issues", exp_op.size(), 32);

      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < DEPTH; i++) begin
            rop = 4'($urandom_range(0, 15));
            if (rop == 4'hE && $urandom_range(0, 3) != 0) rop = 4'h0;
            if (rop == 4'h8) prog_mem[i] = {rop, 8'($urandom_range(0, 3))};
            else prog_mem[i] = {rop, 8'($urandom)};
         end
         write_prog();
         run_prog($sformatf("rand%0d", r), 1, 0);
      end

      // abort mid-run
      for (int i = 0; i < DEPTH; i++) prog_mem[i] = {4'h1, 8'(i)};
      write_prog();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      op_ready = 1'b1;
      n = 0;
      cnt = 0;
      while (n < 5 && cnt < 200) begin
         @(negedge clk);
         cnt++;
         if (op_valid) n++;
      end
      check_val("abort reached", n, 5);
      rst = 1'b1;
      #1;
      check_val("abort op_valid", {31'd0, op_valid}, 0);
      check_val("abort busy", {31'd0, busy}, 0);
      check_val("abort opcode", {28'd0, opcode}, 32'hF);
      n = 0;
      repeat (3) begin
         @(negedge clk);
         if (done || busy) n++;
         rst = 1'b0;
      end
      check_val("abort no_done", n, 0);
      $display("run abort: rst asserted after 5 issues");
      run_prog("after_abort", 0, 1);

`ifdef SEQ_SINGLE_STEP_EN
      fill(12'hE00);
      prog_mem[0] = 12'h005;
      prog_mem[1] = 12'h207;
      prog_mem[2] = 12'hE00;
      write_prog();
      step_en = 1'b1;
      op_ready = 1'b1;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 2; k++) begin
         n = 0;
         repeat (8) begin
            @(negedge clk);
            if (op_valid) n++;
         end
         check_val("step gate", n, 0);
         step = 1'b1;
         @(negedge clk);
         step = 1'b0;
         cnt = 0;
         while (!op_valid && cnt < 6) begin
            @(negedge clk);
            cnt++;
         end
         check_val("step op", {20'd0, op_valid, opcode, op_arg},
                   (k == 0) ? {20'd0, 1'b1, 4'h0, 8'h05} : {20'd0, 1'b1, 4'h2, 8'h07});
      end
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      cnt = 0;
      while (!done && cnt < 6) begin
         @(negedge clk);
         cnt++;
      end
      check_val("step halt", {31'd0, done}, 1);
      step_en = 1'b0;
      op_ready = 1'b0;
      $display("run single_step: two stepped ops and halt");
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
